// File: rtl/lector_pkg.sv
// lector_pkg -- shared definitions for the FIFO drain reader.
//   TAMANO_DATOS_DEF : default data word width
//   ANCHO_CONT_DEF   : default per-port word counter width
//   NUM_PUERTOS      : number of drained FIFOs (F4..F7)
//   IDX_BASE         : counter select value that maps to F4
//   estado_t         : reader FSM states
//   onehot_a_idx     : one-hot grant to binary port index
package lector_pkg;

    localparam int TAMANO_DATOS_DEF = 12;
    localparam int ANCHO_CONT_DEF   = 5;
    localparam int NUM_PUERTOS      = 4;
    localparam int IDX_BASE         = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } estado_t;

    function automatic logic [1:0] onehot_a_idx(input logic [NUM_PUERTOS-1:0] oh);
        logic [1:0] v_idx;
        v_idx = 2'd0;
        for (int i = 0; i < NUM_PUERTOS; i++) begin
            if (oh[i]) v_idx = 2'(i);
        end
        return v_idx;
    endfunction

endpackage

// File: rtl/arbitro_rr4.sv
// arbitro_rr4 -- 4-way combinational round-robin arbiter.
//   i_elig  [3:0] : per-port eligibility
//   i_ptr   [1:0] : highest-priority port this cycle
//   o_grant [3:0] : one-hot grant (all zero when nothing is eligible)
module arbitro_rr4
    import lector_pkg::*;
(
    input  logic [NUM_PUERTOS-1:0] i_elig,
    input  logic [1:0]             i_ptr,
    output logic [NUM_PUERTOS-1:0] o_grant
);

    // Scan the ports starting at i_ptr, wrapping modulo 4; the first
    // eligible one wins.
    always_comb begin
        logic [1:0] v_i;
        logic       v_hit;
        o_grant = '0;
        v_i     = 2'd0;
        v_hit   = 1'b0;
        for (int k = 0; k < NUM_PUERTOS; k++) begin
            v_i = i_ptr + 2'(k);
            if (!v_hit && i_elig[v_i]) begin
                o_grant[v_i] = 1'b1;
                v_hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lector_fifos.sv
// lector_fifos -- drains output FIFOs F4..F7 into a single sink, one word
// per pop, with round-robin fairness, and optionally keeps per-port
// saturating word counters readable through a req/idx interface.
//
// Optional feature macro: LECTOR_CONTADORES_EN (counters and readback).
// Without it cnt_out/cnt_valid are tied to 0 and no counters exist.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   init                : leave IDLE / clear counters
//   empty[3:0]          : FIFO empty flags (bit0 = F4)
//   data_out4..7        : FIFO read data, valid the cycle after pop
//   sink_ready          : downstream accepts a word
//   pop[3:0]            : one-hot pop strobe (bit0 = F4)
//   word_valid/out/port : drained word, its source index (0 = F4)
//   req, idx[2:0]       : counter read request, select 4..7
//   cnt_out, cnt_valid  : counter read response, one cycle after req
module lector_fifos
    import lector_pkg::*;
#(
    parameter int TAMANO_DATOS = TAMANO_DATOS_DEF,
    parameter int ANCHO_CONT   = ANCHO_CONT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [NUM_PUERTOS-1:0]  empty,
    input  logic [TAMANO_DATOS-1:0] data_out4,
    input  logic [TAMANO_DATOS-1:0] data_out5,
    input  logic [TAMANO_DATOS-1:0] data_out6,
    input  logic [TAMANO_DATOS-1:0] data_out7,
    input  logic                    sink_ready,
    output logic [NUM_PUERTOS-1:0]  pop,
    output logic                    word_valid,
    output logic [TAMANO_DATOS-1:0] word_out,
    output logic [1:0]              word_port,
    input  logic                    req,
    input  logic [2:0]              idx,
    output logic [ANCHO_CONT-1:0]   cnt_out,
    output logic                    cnt_valid
);

    estado_t                 r_estado;
    estado_t                 w_estado_sig;
    logic [NUM_PUERTOS-1:0]  r_pop_prev;
    logic [1:0]              r_ptr;
    logic                    r_wv;
    logic [1:0]              r_wport;
    logic [NUM_PUERTOS-1:0]  w_elig;
    logic [NUM_PUERTOS-1:0]  w_grant;
    logic [1:0]              w_gidx;
    logic [TAMANO_DATOS-1:0] w_word;

    // Only reset returns to IDLE.
    always_comb begin
        w_estado_sig = r_estado;
        if (r_estado == IDLE && init) w_estado_sig = ACTIVE;
    end

    // A port popped last cycle is skipped: its empty flag lags one cycle.
    assign w_elig = (r_estado == ACTIVE && sink_ready) ? (~empty & ~r_pop_prev) : '0;

    arbitro_rr4 u_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    assign pop    = w_grant;
    assign w_gidx = onehot_a_idx(w_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado   <= IDLE;
            r_pop_prev <= '0;
            r_ptr      <= 2'd0;
            r_wv       <= 1'b0;
            r_wport    <= 2'd0;
        end else begin
            r_estado   <= w_estado_sig;
            r_pop_prev <= w_grant;
            r_wv       <= |w_grant;
            if (|w_grant) begin
                r_wport <= w_gidx;
                r_ptr   <= w_gidx + 2'd1;
            end
        end
    end

    // FIFO read data arrives the cycle after the pop, so the word is
    // muxed live from the registered grant index.
    always_comb begin
        w_word = '0;
        if (r_wv) begin
            case (r_wport)
                2'd0:    w_word = data_out4;
                2'd1:    w_word = data_out5;
                2'd2:    w_word = data_out6;
                default: w_word = data_out7;
            endcase
        end
    end

    assign word_valid = r_wv;
    assign word_out   = w_word;
    assign word_port  = r_wport;

`ifdef LECTOR_CONTADORES_EN
    localparam logic [ANCHO_CONT-1:0] CNT_MAX = {ANCHO_CONT{1'b1}};

    logic [ANCHO_CONT-1:0] r_cnt     [NUM_PUERTOS];
    logic [ANCHO_CONT-1:0] w_cnt_sig [NUM_PUERTOS];
    logic [ANCHO_CONT-1:0] r_cnt_out;
    logic                  r_cnt_valid;

    // Clear first, then count: a word landing in the init cycle still
    // shows up in the freshly cleared counter.
    always_comb begin
        for (int i = 0; i < NUM_PUERTOS; i++) begin
            w_cnt_sig[i] = init ? '0 : r_cnt[i];
            if (r_wv && r_wport == 2'(i) && w_cnt_sig[i] != CNT_MAX)
                w_cnt_sig[i] = w_cnt_sig[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PUERTOS; i++) r_cnt[i] <= '0;
            r_cnt_out   <= '0;
            r_cnt_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PUERTOS; i++) r_cnt[i] <= w_cnt_sig[i];
            r_cnt_valid <= req;
            // idx 4..7 is exactly idx[2] set; the low bits pick the port.
            r_cnt_out   <= (req && idx[2]) ? r_cnt[idx[1:0]] : '0;
        end
    end

    assign cnt_out   = r_cnt_out;
    assign cnt_valid = r_cnt_valid;
`else
    logic w_unused;
    assign w_unused  = ^{req, idx};
    assign cnt_out   = '0;
    assign cnt_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lector_fifos.sv
module tb_lector_fifos;
    localparam int TD = 12;
    localparam int AC = 5;
    localparam int CMAX = (1 << AC) - 1;
`ifdef LECTOR_CONTADORES_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, init, sink_ready, req;
    logic [3:0]    empty;
    logic [TD-1:0] d4, d5, d6, d7;
    logic [2:0]    idx;
    logic [3:0]    pop;
    logic          word_valid, cnt_valid;
    logic [TD-1:0] word_out;
    logic [1:0]    word_port;
    logic [AC-1:0] cnt_out;

    lector_fifos #(.TAMANO_DATOS(TD), .ANCHO_CONT(AC)) dut (
        .clk(clk), .reset(reset), .init(init), .empty(empty),
        .data_out4(d4), .data_out5(d5), .data_out6(d6), .data_out7(d7),
        .sink_ready(sink_ready), .pop(pop), .word_valid(word_valid),
        .word_out(word_out), .word_port(word_port), .req(req), .idx(idx),
        .cnt_out(cnt_out), .cnt_valid(cnt_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: drain rules stated directly in terms of ports.
    bit m_act   = 0;
    int m_prev  = -1;   // port popped last cycle, -1 if none
    int m_ptr   = 0;    // first port to consider
    int m_cnt[4] = '{0, 0, 0, 0};
    bit m_wv    = 0;
    int m_wport = 0;
    int m_cout  = 0;
    bit m_cval  = 0;

    logic [3:0]    s_pop;
    logic          s_wv, s_cval;
    logic [1:0]    s_wport;
    logic [TD-1:0] s_wout;
    logic [AC-1:0] s_cout;

    function automatic int pick(input logic [3:0] emp, input logic srdy);
        if (!m_act || !srdy) return -1;
        for (int k = 0; k < 4; k++) begin
            int p;
            p = (m_ptr + k) % 4;
            if (!emp[p] && p != m_prev) return p;
        end
        return -1;
    endfunction

    task automatic cyc(input logic rst, input logic ini, input logic [3:0] emp,
                       input logic srdy, input logic rq, input logic [2:0] ix);
        int g;
        int dat[4];
        int nc[4];
        reset = rst; init = ini; empty = emp; sink_ready = srdy; req = rq; idx = ix;
        @(negedge clk);
        dat = '{int'(d4), int'(d5), int'(d6), int'(d7)};
        g = pick(emp, srdy);
        s_pop = pop; s_wv = word_valid; s_wport = word_port; s_wout = word_out;
        s_cout = cnt_out; s_cval = cnt_valid;
        chk("pop", s_pop, (g < 0) ? 0 : (1 << g));
        chk("word_valid", s_wv, m_wv);
        if (m_wv) begin
            chk("word_port", s_wport, m_wport);
            chk("word_out", s_wout, dat[m_wport]);
        end else begin
            chk("word_out_idle", s_wout, 0);
        end
        chk("cnt_valid", s_cval, CNT_EN ? m_cval : 0);
        chk("cnt_out", s_cout, CNT_EN ? m_cout : 0);
        @(posedge clk);
        if (rst) begin
            m_act = 0; m_prev = -1; m_ptr = 0; m_cnt = '{0, 0, 0, 0};
            m_wv = 0; m_wport = 0; m_cout = 0; m_cval = 0;
        end else begin
            m_cval = rq;
            m_cout = (rq && ix >= 4) ? m_cnt[int'(ix) - 4] : 0;
            nc = m_cnt;
            if (ini) nc = '{0, 0, 0, 0};
            if (m_wv && nc[m_wport] < CMAX) nc[m_wport]++;
            m_cnt = nc;
            m_wv = (g >= 0);
            if (g >= 0) begin
                m_wport = g;
                m_ptr = (g + 1) % 4;
            end
            m_prev = g;
            if (ini) m_act = 1;
        end
        #1;
    endtask

    typedef struct {
        logic       rst, ini;
        logic [3:0] emp;
        logic       srdy, rq;
        logic [2:0] ix;
        logic [3:0] e_pop;
        logic       e_wv;
        logic [1:0] e_port;
        int         e_cnt;   // -1: not checked on this row
    } vec_t;

    vec_t tv[21];

    function automatic vec_t mk(input logic rst, ini, input logic [3:0] emp,
                                input logic srdy, rq, input logic [2:0] ix,
                                input logic [3:0] e_pop, input logic e_wv,
                                input logic [1:0] e_port, input int e_cnt);
        vec_t v;
        v.rst = rst; v.ini = ini; v.emp = emp; v.srdy = srdy; v.rq = rq; v.ix = ix;
        v.e_pop = e_pop; v.e_wv = e_wv; v.e_port = e_port; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        // Scenario 1: only F4 has data, pops every other cycle.
        tv[0]  = mk(1, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 0, 0);
        tv[1]  = mk(0, 1, 4'b1110, 1, 0, 0, 4'b0000, 0, 0, -1);
        tv[2]  = mk(0, 0, 4'b1110, 1, 0, 0, 4'b0001, 0, 0, -1);
        tv[3]  = mk(0, 0, 4'b1110, 1, 0, 0, 4'b0000, 1, 0, -1);
        tv[4]  = mk(0, 0, 4'b1110, 1, 0, 0, 4'b0001, 0, 0, -1);
        tv[5]  = mk(0, 0, 4'b1110, 1, 0, 0, 4'b0000, 1, 0, -1);
        // Scenario 2: all four full, strict rotation F4..F7 twice.
        tv[6]  = mk(1, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 0, -1);
        tv[7]  = mk(0, 1, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, -1);
        tv[8]  = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0001, 0, 0, -1);
        tv[9]  = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0010, 1, 0, -1);
        tv[10] = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0100, 1, 1, -1);
        tv[11] = mk(0, 0, 4'b0000, 1, 0, 0, 4'b1000, 1, 2, -1);
        tv[12] = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0001, 1, 3, -1);
        tv[13] = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0010, 1, 0, -1);
        tv[14] = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0100, 1, 1, -1);
        tv[15] = mk(0, 0, 4'b0000, 1, 0, 0, 4'b1000, 1, 2, -1);
        tv[16] = mk(0, 0, 4'b1111, 1, 0, 0, 4'b0000, 1, 3, -1);
        tv[17] = mk(0, 0, 4'b1111, 1, 1, 4, 4'b0000, 0, 0, -1);
        tv[18] = mk(0, 0, 4'b1111, 1, 1, 7, 4'b0000, 0, 0, 2);
        tv[19] = mk(0, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 0, 2);
        tv[20] = mk(0, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 0, 0);

        d4 = 12'h0FF; d5 = 12'h1A5; d6 = 12'h2B6; d7 = 12'h3C7;
        reset = 1; init = 0; empty = 4'hF; sink_ready = 1; req = 0; idx = 0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            cyc(tv[i].rst, tv[i].ini, tv[i].emp, tv[i].srdy, tv[i].rq, tv[i].ix);
            chk($sformatf("tbl%0d_pop", i), s_pop, tv[i].e_pop);
            chk($sformatf("tbl%0d_wv", i), s_wv, tv[i].e_wv);
            if (tv[i].e_wv) chk($sformatf("tbl%0d_port", i), s_wport, tv[i].e_port);
            if (tv[i].e_cnt >= 0)
                chk($sformatf("tbl%0d_cnt", i), s_cout, CNT_EN ? tv[i].e_cnt : 0);
        end

        // Scenario 3: sink_ready low for 3 cycles mid-drain.
        cyc(1, 0, 4'hF, 1, 0, 0);
        cyc(0, 1, 4'h0, 1, 0, 0);
        repeat (3) cyc(0, 0, 4'h0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 4'h0, 0, 0, 0);
            chk("stall_pop", s_pop, 0);
            if (k == 0) chk("stall_trailing_wv", s_wv, 1);
        end
        cyc(0, 0, 4'h0, 1, 0, 0);
        chk("stall_resume_f7", s_pop, 4'b1000);
        repeat (4) cyc(0, 0, 4'h0, 1, 0, 0);

        // Scenario 4: 41 words from F5 saturate its counter.
        cyc(1, 0, 4'hF, 1, 0, 0);
        cyc(0, 1, 4'b1101, 1, 0, 0);
        repeat (82) cyc(0, 0, 4'b1101, 1, 0, 0);
        cyc(0, 0, 4'hF, 1, 1, 5);
        cyc(0, 0, 4'hF, 1, 1, 2);
        chk("sat_cnt_out", s_cout, CNT_EN ? CMAX : 0);
        chk("sat_cnt_valid", s_cval, CNT_EN);
        cyc(0, 0, 4'hF, 1, 0, 0);
        chk("oob_cnt_out", s_cout, 0);
        chk("oob_cnt_valid", s_cval, CNT_EN);

        // Scenario 5: reset while a pop is in flight.
        cyc(1, 0, 4'hF, 1, 0, 0);
        cyc(0, 1, 4'h0, 1, 0, 0);
        cyc(0, 0, 4'h0, 1, 0, 0);
        cyc(1, 0, 4'h0, 1, 1, 4);
        chk("rst_pop_was_live", s_pop, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 4'h0, 1, 0, 0);
            chk("rst_wv", s_wv, 0);
            chk("rst_pop", s_pop, 0);
            chk("rst_wout", s_wout, 0);
            chk("rst_cval", s_cval, 0);
        end
        cyc(0, 1, 4'h0, 1, 0, 0);
        cyc(0, 0, 4'h0, 1, 0, 0);
        chk("rst_restart_f4", s_pop, 4'b0001);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            d4 = TD'($urandom); d5 = TD'($urandom); d6 = TD'($urandom); d7 = TD'($urandom);
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
                4'($urandom), ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 2) == 0), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
